// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: two request ports plus the shared ack/rdata return.
// The master modport is the CPU side; the slave modport is the arbiter.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between fetch (port 0) and load/store
// (port 1); sequences ce_n/oe_n/we_n with programmable wait states, all pins registered.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WRITE_PULSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_arbiter_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  drive_q;
  logic                  ce_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;
  logic                  ack0_q;
  logic                  ack1_q;

  logic                  grant_d;
  logic                  sel_we_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;

  // Contested cycle goes to the port that did not win last time; a lone request wins outright.
  always_comb begin
    grant_d     = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    sel_we_d    = grant_d ? bus.we1    : bus.we0;
    sel_addr_d  = grant_d ? bus.addr1  : bus.addr0;
    sel_wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      drive_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            ce_n_q       <= 1'b0;
            if (sel_we_d) begin
              drive_q <= 1'b1;
              state_q <= WR_SETUP;
            end else begin
              oe_n_q  <= 1'b0;
              cnt_q   <= RD_LOAD;
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (cnt_q == '0) begin
            rdata_q <= sram_data;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= WR_LOAD;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_HOLD: begin
          ce_n_q  <= 1'b1;
          drive_q <= 1'b0;
          ack0_q  <= ~grant_q;
          ack1_q  <= grant_q;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          drive_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_data = drive_q ? wdata_q : 'z;

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (default and slow timing) each with an SRAM model,
// checked against a transaction-level timeline model of arbitration, latency and data.
module tb_sram_arbiter;
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 32;
  localparam int unsigned RW0 = 1;
  localparam int unsigned WP0 = 1;
  localparam int unsigned RW1 = 3;
  localparam int unsigned WP1 = 2;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   delay;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned npass  = 0;
  int unsigned nfail  = 0;
  int unsigned ntotal = 0;

  logic          req_v   [2][2];
  logic          we_v    [2][2];
  logic [AW-1:0] addr_v  [2][2];
  logic [DW-1:0] wdata_v [2][2];
  logic          ack_w   [2][2];
  logic [DW-1:0] rdata_w [2];
  logic [AW-1:0] saddr_w [2];
  logic          ce_w    [2];
  logic          oe_w    [2];
  logic          we_w    [2];
  logic          drv_w   [2];

  bit            lg      [2];
  int unsigned   free_at [2];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] ref_mem [logic [AW:0]];
  logic [AW-1:0] pool    [8];
  txn_t          q0[$];
  txn_t          q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] hsh(input logic [AW-1:0] a);
    return a[19:10] ^ a[9:0];
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int g, input logic [AW-1:0] a);
    logic [AW:0] k;
    k = {g[0], a};
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  function automatic int unsigned rdlat(input int g);
    return (g == 0) ? RW0 + 2 : RW1 + 2;
  endfunction

  function automatic int unsigned wrlat(input int g);
    return (g == 0) ? WP0 + 3 : WP1 + 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned GRW = (g == 0) ? RW0 : RW1;
    localparam int unsigned GWP = (g == 0) ? WP0 : WP1;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    wire  [DW-1:0] sdata;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd_val = '0;
    int unsigned   oe_run = 0;
    int unsigned   we_run = 0;

    assign bus.req0   = req_v[g][0];
    assign bus.req1   = req_v[g][1];
    assign bus.we0    = we_v[g][0];
    assign bus.we1    = we_v[g][1];
    assign bus.addr0  = addr_v[g][0];
    assign bus.addr1  = addr_v[g][1];
    assign bus.wdata0 = wdata_v[g][0];
    assign bus.wdata1 = wdata_v[g][1];
    assign ack_w[g][0] = bus.ack0;
    assign ack_w[g][1] = bus.ack1;
    assign rdata_w[g]  = bus.rdata;
    assign drv_w[g]    = u_dut.drive_q;

    sram_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .READ_WAIT  (GRW),
      .WRITE_PULSE(GWP)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .sram_addr(saddr_w[g]),
      .sram_data(sdata),
      .sram_ce_n(ce_w[g]),
      .sram_oe_n(oe_w[g]),
      .sram_we_n(we_w[g])
    );

    initial for (int i = 0; i < 1024; i++) mem[i] = '0;

    assign sdata = (!ce_w[g] && !oe_w[g] && we_w[g]) ? rd_val : 'z;

    always @(negedge clk) begin
      if (!ce_w[g] && !we_w[g]) mem[hsh(saddr_w[g])] <= sdata;
      rd_val <= mem[hsh(saddr_w[g])];
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d_oe_we_overlap", g), 64'(!oe_w[g] && !we_w[g]), 64'(0));
      chk($sformatf("g%0d_bus_driven_while_oe", g), 64'(drv_w[g] && !oe_w[g]), 64'(0));
      if (!rst_n) begin
        oe_run <= 0;
        we_run <= 0;
      end else begin
        if (!oe_w[g]) oe_run <= oe_run + 1;
        else begin
          if (oe_run != 0) chk($sformatf("g%0d_oe_low_cycles", g), 64'(oe_run), 64'(GRW + 1));
          oe_run <= 0;
        end
        if (!we_w[g]) we_run <= we_run + 1;
        else begin
          if (we_run != 0) chk($sformatf("g%0d_we_low_cycles", g), 64'(we_run), 64'(GWP));
          we_run <= 0;
        end
      end
    end
  end

  task automatic push(input int p, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int unsigned dly);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.delay = dly;
    if (p == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      lg[g]      = 1'b1;
      free_at[g] = cyc;
      last_rd[g] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Timeline model: the arbiter is free at free_at; a grant at cycle c acks at c+latency.
  task automatic run(input int g, input int unsigned budget);
    txn_t        cur  [2];
    bit          act  [2];
    bit          gr   [2];
    int unsigned ack_at [2];
    int unsigned idle [2];
    int unsigned oth  [2];
    int unsigned t0;
    t0 = cyc;
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; gr[p] = 0; ack_at[p] = 0; idle[p] = 0; oth[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        logic e;
        logic [DW-1:0] ev;
        e = gr[p] && (ack_at[p] == cyc);
        chk($sformatf("g%0d_ack%0d_c%0d", g, p, cyc), 64'(ack_w[g][p]), 64'(e));
        if (e) begin
          if (cur[p].we) begin
            ref_mem[{g[0], cur[p].addr}] = cur[p].data;
            chk($sformatf("g%0d_rdata_kept_on_write", g), 64'(rdata_w[g]), 64'(last_rd[g]));
          end else begin
            ev = ref_rd(g, cur[p].addr);
            chk($sformatf("g%0d_rdata_p%0d", g, p), 64'(rdata_w[g]), 64'(ev));
            last_rd[g] = ev;
          end
          chk($sformatf("g%0d_p%0d_wait_bound", g, p), 64'(oth[p] <= 1), 64'(1));
          if (act[1-p]) oth[1-p]++;
          gr[p] = 0; act[p] = 0; idle[p] = 0;
          req_v[g][p] = 1'b0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ((p == 0) ? q0.size() : q1.size()) > 0) begin
          txn_t t;
          t = (p == 0) ? q0[0] : q1[0];
          if (idle[p] >= t.delay) begin
            if (p == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            cur[p] = t; act[p] = 1; oth[p] = 0;
            req_v[g][p] = 1'b1; we_v[g][p] = t.we;
            addr_v[g][p] = t.addr; wdata_v[g][p] = t.data;
          end else idle[p]++;
        end
      end
      if (cyc >= free_at[g]) begin
        bit p0, p1, w;
        p0 = act[0] && !gr[0];
        p1 = act[1] && !gr[1];
        if (p0 || p1) begin
          w = (p0 && p1) ? !lg[g] : p1;
          lg[g] = w;
          gr[w] = 1;
          ack_at[w] = cyc + (cur[w].we ? wrlat(g) : rdlat(g));
          free_at[g] = ack_at[w] + 1;
        end
      end
      if (!act[0] && !act[1] && q0.size() == 0 && q1.size() == 0 && cyc >= free_at[g]) break;
      if (cyc - t0 > budget) begin
        ntotal++;
        nfail++;
        $error("FAIL g%0d_run_timeout: observed no completion after %0d cycles, required completion", g, budget);
        req_v[g][0] = 1'b0; req_v[g][1] = 1'b0;
        q0.delete(); q1.delete();
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: observed simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) begin
        req_v[g][p] = 1'b0; we_v[g][p] = 1'b0; addr_v[g][p] = '0; wdata_v[g][p] = '0;
      end
    for (int i = 0; i < 8; i++) begin
      logic [9:0] hi;
      logic [9:0] iv;
      hi = 10'($urandom_range(0, 1023));
      iv = 10'(i);
      pool[i] = {hi, hi ^ iv};
    end

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d_rst_strobes", g), 64'({ce_w[g], oe_w[g], we_w[g]}), 64'(3'b111));
      chk($sformatf("g%0d_rst_acks", g), 64'({ack_w[g][0], ack_w[g][1]}), 64'(0));
      chk($sformatf("g%0d_rst_rdata", g), 64'(rdata_w[g]), 64'(0));
      chk($sformatf("g%0d_rst_addr", g), 64'(saddr_w[g]), 64'(0));
      chk($sformatf("g%0d_rst_bus_drive", g), 64'(drv_w[g]), 64'(0));
    end
    rst_n = 1'b1;
    model_reset();

    for (int g = 0; g < 2; g++) begin
      push(1, 1'b1, 20'h00010, 32'hDEADBEEF, 0);
      run(g, 100);
      push(0, 1'b0, 20'h00010, '0, 0);
      run(g, 100);
      chk($sformatf("g%0d_read_back_deadbeef", g), 64'(rdata_w[g]), 64'(32'hDEADBEEF));

      do_reset();
      push(0, 1'b0, pool[0], '0, 0);
      push(1, 1'b0, pool[1], '0, 0);
      run(g, 100);
      push(0, 1'b0, pool[2], '0, 0);
      push(1, 1'b0, 20'h00010, '0, 0);
      run(g, 100);

      for (int i = 0; i < 4; i++) push(0, 1'(i % 2), pool[i], $urandom, 0);
      push(1, 1'b0, pool[0], '0, 1);
      run(g, 200);

      for (int i = 0; i < 30; i++) begin
        push(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 3));
        push(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 3));
      end
      run(g, 3000);
    end

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        chk($sformatf("g%0d_idle_pins", g),
            64'({ce_w[g], oe_w[g], we_w[g], ack_w[g][0], ack_w[g][1], drv_w[g]}), 64'(6'b111000));
    end

    for (int g = 1; g >= 0; g--) begin
      int unsigned n;
      logic [AW-1:0] ra;
      ra = {10'h155, 10'h155 ^ 10'd1000};
      @(negedge clk);
      req_v[g][1] = 1'b1; we_v[g][1] = 1'b1; addr_v[g][1] = ra; wdata_v[g][1] = 32'hA5A5_0F0F;
      n = 0;
      while (we_w[g] !== 1'b0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("g%0d_reached_wr_pulse", g), 64'(we_w[g]), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("g%0d_mid_rst_strobes", g), 64'({ce_w[g], oe_w[g], we_w[g]}), 64'(3'b111));
      chk($sformatf("g%0d_mid_rst_bus_drive", g), 64'(drv_w[g]), 64'(0));
      req_v[g][1] = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk($sformatf("g%0d_mid_rst_no_ack", g), 64'({ack_w[g][0], ack_w[g][1]}), 64'(0));
      end
      rst_n = 1'b1;
      model_reset();
      repeat (6) begin
        @(negedge clk);
        chk($sformatf("g%0d_post_rst_quiet", g),
            64'({ce_w[g], we_w[g], ack_w[g][0], ack_w[g][1]}), 64'(4'b1100));
      end
    end

    push(0, 1'b0, pool[3], '0, 0);
    push(1, 1'b0, pool[4], '0, 0);
    run(1, 100);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
